// File: rtl/uart_rx.sv
// UART receiver: oversampled serial line to parallel word with parity/stop checks.
// Latency: data_valid rises OVERSAMPLE/2 + OVERSAMPLE*(DATA_BITS+PARITY_EN+1) + 3 edges after the first low rx sample.
// Backpressure: none; every accepted frame strobes data_valid and overwrites data_out.
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1
) (
  input  logic                 clk_t,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] TICK_MAX  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    WAIT_HI = 3'd5
  } state_t;

  state_t               state;
  logic [TW-1:0]        tick;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_bit;
  logic                 rx_m;
  logic                 rx_s;

  // Two-flop synchroniser; resets to the idle-high line level so reset never fakes a start bit.
  always_ff @(posedge clk_t or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Frame FSM with counters and registered outputs; strobes default low every cycle.
  always_ff @(posedge clk_t or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tick       <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      par_bit    <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            tick  <= '0;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (tick == TICK_HALF) begin
            tick    <= '0;
            bit_idx <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              // Start bit vanished by mid-bit: treat as line noise.
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            tick <= tick + TW'(1);
          end
        end

        DATA: begin
          if (tick == TICK_MAX) begin
            tick      <= '0;
            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
            bit_idx   <= bit_idx + BW'(1);
            if (bit_idx == BIT_LAST) begin
              state <= (PARITY_EN != 0) ? PARITY : STOP;
            end
          end else begin
            tick <= tick + TW'(1);
          end
        end

        PARITY: begin
          if (tick == TICK_MAX) begin
            tick    <= '0;
            par_bit <= rx_s;
            state   <= STOP;
          end else begin
            tick <= tick + TW'(1);
          end
        end

        STOP: begin
          if (tick == TICK_MAX) begin
            tick <= '0;
            if (rx_s) begin
              data_out   <= shift_reg;
              data_valid <= 1'b1;
              parity_err <= (PARITY_EN != 0) ? (par_bit ^ (^shift_reg)) : 1'b0;
              state      <= IDLE;
              busy       <= 1'b0;
            end else begin
              // Bad stop bit: drop the word and wait out a possible break.
              frame_err <= 1'b1;
              state     <= WAIT_HI;
            end
          end else begin
            tick <= tick + TW'(1);
          end
        end

        WAIT_HI: begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int OS  = 16;
  localparam int LAT = 171; // cycles from driving the start bit to sampling data_valid

  logic       clk_t;
  logic       rst_n;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int vectors;
  int miscompares;
  int cyc;
  int fe_cnt;
  int stray;
  logic prev_vld;

  int         vcyc_q[$];
  logic [7:0] vdat_q[$];
  logic       vpe_q[$];

  uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(8), .PARITY_EN(1)) dut (
    .clk_t      (clk_t),
    .rst_n      (rst_n),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk_t = 1'b0;
  always #5 clk_t = ~clk_t;

  always @(posedge clk_t) cyc <= cyc + 1;

  // Record every strobe away from the active edge.
  always @(negedge clk_t) begin
    if (data_valid === 1'b1) begin
      vcyc_q.push_back(cyc);
      vdat_q.push_back(data_out);
      vpe_q.push_back(parity_err);
      if (prev_vld === 1'b1) stray++;
    end
    if (data_valid !== 1'b1 && parity_err !== 1'b0) stray++;
    if (frame_err === 1'b1) fe_cnt++;
    prev_vld = data_valid;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (OS) @(posedge clk_t);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk_t);
    #1;
  endtask

  // Full frame; parity is even parity of d, optionally inverted.
  task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop_v,
                            output int start);
    start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit((^d) ^ flip);
    drive_bit(stop_v);
  endtask

  // Reference: a good-stop frame yields one strobe LAT cycles after its start, carrying
  // the byte and a parity flag equal to whether the parity bit was corrupted.
  task automatic expect_frame(input string tag, input logic [7:0] d, input logic pe, input int start);
    if (vcyc_q.size() == 0) begin
      check({tag, "_present"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_cycle"}, vcyc_q.pop_front(), start + LAT);
      check({tag, "_data"},  {24'd0, vdat_q.pop_front()}, {24'd0, d});
      check({tag, "_perr"},  {31'd0, vpe_q.pop_front()}, {31'd0, pe});
    end
  endtask

  initial begin
    int s0, s1, s2, fe_base, gap;
    logic [7:0] rd;
    logic rf;
    vectors = 0; miscompares = 0; cyc = 0; fe_cnt = 0; stray = 0; prev_vld = 1'b0;
    rx = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk_t);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_data", {24'd0, data_out}, 32'd0);
    check("rst_vld", {31'd0, data_valid}, 32'd0);
    @(negedge clk_t);
    rst_n = 1'b1;
    @(posedge clk_t);
    #1;

    // 1. idle line
    idle_cycles(100);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_nvalid", vcyc_q.size(), 32'd0);
    check("idle_data", {24'd0, data_out}, 32'd0);

    // 2. clean frame
    send_frame(8'hA5, 1'b0, 1'b1, s0);
    expect_frame("a5", 8'hA5, 1'b0, s0);
    idle_cycles(10);

    // 3. parity error still delivers the word
    send_frame(8'h3C, 1'b1, 1'b1, s0);
    expect_frame("3c", 8'h3C, 1'b1, s0);
    idle_cycles(10);

    // 4. framing error followed by a held-low line
    fe_base = fe_cnt;
    send_frame(8'h55, 1'b0, 1'b0, s0);
    rx = 1'b0;
    repeat (64) @(posedge clk_t);
    #1;
    check("fe_busy_low", {31'd0, busy}, 32'd1);
    check("fe_pulses", fe_cnt - fe_base, 32'd1);
    check("fe_nvalid", vcyc_q.size(), 32'd0);
    check("fe_data_held", {24'd0, data_out}, 32'h3C);
    idle_cycles(4);
    check("fe_busy_rel", {31'd0, busy}, 32'd0);
    idle_cycles(20);

    // 5. start glitch
    fe_base = fe_cnt;
    rx = 1'b0;
    repeat (5) @(posedge clk_t);
    #1;
    check("gl_busy_in", {31'd0, busy}, 32'd1);
    idle_cycles(20);
    check("gl_busy_out", {31'd0, busy}, 32'd0);
    check("gl_nvalid", vcyc_q.size(), 32'd0);
    check("gl_nfe", fe_cnt - fe_base, 32'd0);

    // 6. back-to-back frames, then reset during a third
    send_frame(8'h01, 1'b0, 1'b1, s0);
    send_frame(8'hFF, 1'b0, 1'b1, s1);
    expect_frame("b2b0", 8'h01, 1'b0, s0);
    expect_frame("b2b1", 8'hFF, 1'b0, s1);
    s2 = cyc;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rst_n = 1'b0;
    #2;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_data", {24'd0, data_out}, 32'd0);
    rx = 1'b1;
    @(negedge clk_t);
    rst_n = 1'b1;
    @(posedge clk_t);
    #1;
    idle_cycles(200);
    check("mid_rst_nvalid", vcyc_q.size(), 32'd0);
    check("mid_rst_start_used", {31'd0, s2 > 0}, 32'd1);

    // Randomized frames with random gaps and parity corruption
    for (int k = 0; k < 8; k++) begin
      rd  = 8'($urandom);
      rf  = 1'($urandom_range(0, 1));
      gap = $urandom_range(0, 12);
      idle_cycles(gap);
      send_frame(rd, rf, 1'b1, s0);
      expect_frame("rand", rd, rf, s0);
    end
    idle_cycles(20);

    check("no_stray_strobes", stray, 32'd0);
    check("fe_total", fe_cnt, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
